// File: rtl/frame_loader.sv
// Frame-buffer writer for the LED matrix scanner: back buffer, committed front
// buffer, and the e_disp/d_disp handshake with a completed-frame counter.
module frame_loader #(
  parameter int unsigned GS = 8,
  parameter int unsigned RW = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [RW-1:0]      wr_row_i,
  input  logic [GS-1:0]      wr_data_i,
  input  logic               clear_i,
  input  logic               commit_i,
  input  logic               d_disp_i,
  output logic [GS*GS-1:0]   matrix_o,
  output logic               e_disp_o,
  output logic               busy_o,
  output logic               pend_o,
  output logic [7:0]         frame_cnt_o
);

  localparam int unsigned CW = 8;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHOW    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // Packed rows flatten directly to bit index row*GS + col.
  logic [GS-1:0][GS-1:0] bb_q, bb_d;
  logic [1:0]            state_q, state_d;
  logic [GS*GS-1:0]      matrix_q, matrix_d;
  logic                  e_disp_q, e_disp_d;
  logic                  busy_q, busy_d;
  logic                  pend_q, pend_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_ok;
  logic                  load;

  // Back-buffer update: clear first, then the row write on top of it.
  always_comb begin
    wr_ok = wr_en_i && ({1'b0, wr_row_i} < (RW+1)'(GS));
    for (int r = 0; r < GS; r++) begin
      bb_d[r] = clear_i ? '0 : bb_q[r];
      if (wr_ok && (wr_row_i == RW'(r))) bb_d[r] = wr_data_i;
    end
  end

  // Next-state and output logic; a load copies the bypassed back buffer.
  always_comb begin
    state_d  = state_q;
    matrix_d = matrix_q;
    e_disp_d = e_disp_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_i || pend_q) load = 1'b1;
      end
      S_SHOW: begin
        if (commit_i) pend_d = 1'b1;
        if (d_disp_i) begin
          e_disp_d = 1'b0;
          cnt_d    = cnt_q + CW'(1);
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!d_disp_i) begin
          if (pend_q || commit_i) load = 1'b1;
          else                    state_d = S_IDLE;
        end else if (commit_i) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d  = S_SHOW;
      matrix_d = bb_d;
      e_disp_d = 1'b1;
      pend_d   = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bb_q     <= '0;
      state_q  <= S_IDLE;
      matrix_q <= '0;
      e_disp_q <= 1'b0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      bb_q     <= bb_d;
      state_q  <= state_d;
      matrix_q <= matrix_d;
      e_disp_q <= e_disp_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign matrix_o    = matrix_q;
  assign e_disp_o    = e_disp_q;
  assign busy_o      = busy_q;
  assign pend_o      = pend_q;
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: scoreboard of expected front-buffer
// images, pushed when a load is provoked and popped when the frame appears.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [2:0]  wr_row_i = '0;
  logic [7:0]  wr_data_i = '0;
  logic        clear_i = 1'b0;
  logic        commit_i = 1'b0;
  logic        d_disp_i = 1'b0;
  logic [63:0] matrix_o;
  logic        e_disp_o, busy_o, pend_o;
  logic [7:0]  frame_cnt_o;

  // Second instance with GS < 2^RW to exercise out-of-range rows.
  logic        wr2_en = 1'b0;
  logic [2:0]  wr2_row = '0;
  logic [4:0]  wr2_data = '0;
  logic        commit2 = 1'b0;
  logic [24:0] m2;
  logic        e2, b2, p2;
  logic [7:0]  c2;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] mdl_bb = '0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_m;

  always #5 clk = ~clk;

  frame_loader #(.GS(8), .RW(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_row_i(wr_row_i),
    .wr_data_i(wr_data_i), .clear_i(clear_i), .commit_i(commit_i),
    .d_disp_i(d_disp_i), .matrix_o(matrix_o), .e_disp_o(e_disp_o),
    .busy_o(busy_o), .pend_o(pend_o), .frame_cnt_o(frame_cnt_o)
  );

  frame_loader #(.GS(5), .RW(3)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr2_en), .wr_row_i(wr2_row),
    .wr_data_i(wr2_data), .clear_i(1'b0), .commit_i(commit2),
    .d_disp_i(1'b0), .matrix_o(m2), .e_disp_o(e2),
    .busy_o(b2), .pend_o(p2), .frame_cnt_o(c2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    wr_en_i = 1'b1; wr_row_i = 3'(r); wr_data_i = d;
    mdl_bb[r*8 +: 8] = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic pop_exp(output logic [63:0] m);
    if (exp_q.size() == 0) begin
      m = 'x;
    end else begin
      m = exp_q.pop_front();
    end
  endtask

  task automatic end_frame();
    d_disp_i = 1'b1; tick();
    d_disp_i = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    mdl_bb = '0;
    n_total++; if (matrix_o !== 64'h0) $display("FAIL reset_matrix got %h want 0", matrix_o); else n_pass++;
    n_total++; if ({e_disp_o, busy_o, pend_o} !== 3'b000) $display("FAIL reset_flags got %b want 000", {e_disp_o, busy_o, pend_o}); else n_pass++;
    n_total++; if (frame_cnt_o !== 8'd0) $display("FAIL reset_cnt got %0d want 0", frame_cnt_o); else n_pass++;
  endtask

  task automatic test_diagonal();
    for (int r = 0; r < 8; r++) write_row(r, 8'(1 << r));
    commit_i = 1'b1; exp_q.push_back(mdl_bb); tick(); commit_i = 1'b0;
    pop_exp(exp_m);
    n_total++; if (matrix_o !== exp_m) $display("FAIL diag_sb got %h want %h", matrix_o, exp_m); else n_pass++;
    n_total++; if (matrix_o !== 64'h8040_2010_0804_0201) $display("FAIL diag_const got %h want 8040201008040201", matrix_o); else n_pass++;
    n_total++; if ({e_disp_o, busy_o} !== 2'b11) $display("FAIL diag_en got %b want 11", {e_disp_o, busy_o}); else n_pass++;
    tick(); tick();
    n_total++; if (e_disp_o !== 1'b1) $display("FAIL diag_hold got %b want 1", e_disp_o); else n_pass++;
    d_disp_i = 1'b1; tick(); d_disp_i = 1'b0;
    n_total++; if ({e_disp_o, frame_cnt_o} !== {1'b0, 8'd1}) $display("FAIL diag_done got e=%b cnt=%0d want e=0 cnt=1", e_disp_o, frame_cnt_o); else n_pass++;
    tick();
    n_total++; if (busy_o !== 1'b0) $display("FAIL diag_idle got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_bypass();
    wr_en_i = 1'b1; wr_row_i = 3'd5; wr_data_i = 8'hA5; commit_i = 1'b1;
    mdl_bb[47:40] = 8'hA5; exp_q.push_back(mdl_bb);
    tick(); wr_en_i = 1'b0; commit_i = 1'b0;
    pop_exp(exp_m);
    n_total++; if (matrix_o[47:40] !== 8'hA5) $display("FAIL bypass_row got %h want a5", matrix_o[47:40]); else n_pass++;
    n_total++; if (matrix_o !== exp_m) $display("FAIL bypass_sb got %h want %h", matrix_o, exp_m); else n_pass++;
    end_frame();
  endtask

  task automatic test_commit_busy();
    logic [63:0] frame_a;
    commit_i = 1'b1; exp_q.push_back(mdl_bb); tick(); commit_i = 1'b0;
    pop_exp(exp_m); frame_a = exp_m;
    n_total++; if (matrix_o !== exp_m) $display("FAIL busy_a got %h want %h", matrix_o, exp_m); else n_pass++;
    commit_i = 1'b1; write_row(0, 8'hFF);
    tick(); commit_i = 1'b0;
    n_total++; if ({pend_o, e_disp_o} !== 2'b11) $display("FAIL busy_pend got %b want 11", {pend_o, e_disp_o}); else n_pass++;
    n_total++; if (matrix_o !== frame_a) $display("FAIL busy_stable got %h want %h", matrix_o, frame_a); else n_pass++;
    d_disp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if ({e_disp_o, frame_cnt_o} !== {1'b0, 8'd3}) $display("FAIL busy_hold%0d got e=%b cnt=%0d want e=0 cnt=3", i, e_disp_o, frame_cnt_o); else n_pass++;
    end
    d_disp_i = 1'b0; exp_q.push_back(mdl_bb); tick();
    pop_exp(exp_m);
    n_total++; if ({e_disp_o, pend_o} !== 2'b10) $display("FAIL busy_reload got e=%b p=%b want e=1 p=0", e_disp_o, pend_o); else n_pass++;
    n_total++; if (matrix_o !== exp_m || matrix_o[7:0] !== 8'hFF) $display("FAIL busy_sb got %h want %h", matrix_o, exp_m); else n_pass++;
    end_frame();
    n_total++; if ({busy_o, frame_cnt_o} !== {1'b0, 8'd4}) $display("FAIL busy_end got b=%b cnt=%0d want b=0 cnt=4", busy_o, frame_cnt_o); else n_pass++;
  endtask

  task automatic test_clear_write();
    for (int r = 0; r < 8; r++) write_row(r, 8'hFF);
    clear_i = 1'b1; mdl_bb = '0; write_row(2, 8'h3C); clear_i = 1'b0;
    commit_i = 1'b1; exp_q.push_back(mdl_bb); tick(); commit_i = 1'b0;
    pop_exp(exp_m);
    n_total++; if (matrix_o !== 64'h0000_0000_003C_0000) $display("FAIL clr_const got %h want 00000000003c0000", matrix_o); else n_pass++;
    n_total++; if (matrix_o !== exp_m) $display("FAIL clr_sb got %h want %h", matrix_o, exp_m); else n_pass++;
    end_frame();
  endtask

  task automatic test_reset_mid();
    commit_i = 1'b1; tick(); commit_i = 1'b0;
    rst_i = 1'b1; tick(); rst_i = 1'b0; mdl_bb = '0;
    n_total++; if ({e_disp_o, busy_o, pend_o} !== 3'b000) $display("FAIL rstmid_flags got %b want 000", {e_disp_o, busy_o, pend_o}); else n_pass++;
    n_total++; if (matrix_o !== 64'h0 || frame_cnt_o !== 8'd0) $display("FAIL rstmid_data got m=%h cnt=%0d want 0", matrix_o, frame_cnt_o); else n_pass++;
    d_disp_i = 1'b1; tick(); tick(); d_disp_i = 1'b0; tick();
    n_total++; if ({busy_o, frame_cnt_o} !== 9'd0) $display("FAIL idle_done got b=%b cnt=%0d want 0", busy_o, frame_cnt_o); else n_pass++;
    rst_i = 1'b1; commit_i = 1'b1; tick(); rst_i = 1'b0; commit_i = 1'b0; tick();
    n_total++; if ({busy_o, pend_o, e_disp_o} !== 3'b000) $display("FAIL rst_commit got %b want 000", {busy_o, pend_o, e_disp_o}); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int f = 0; f < 256; f++) begin
      write_row(f % 8, 8'(f));
      commit_i = 1'b1; exp_q.push_back(mdl_bb); tick(); commit_i = 1'b0;
      pop_exp(exp_m);
      n_total++; if (e_disp_o !== 1'b1 || matrix_o !== exp_m) $display("FAIL wrap_frame%0d got e=%b m=%h want e=1 m=%h", f, e_disp_o, matrix_o, exp_m); else n_pass++;
      end_frame();
      if (f == 254) begin
        n_total++; if (frame_cnt_o !== 8'd255) $display("FAIL wrap_255 got %0d want 255", frame_cnt_o); else n_pass++;
      end
    end
    n_total++; if (frame_cnt_o !== 8'd0) $display("FAIL wrap_zero got %0d want 0", frame_cnt_o); else n_pass++;
  endtask

  task automatic test_invalid_row();
    wr2_en = 1'b1; wr2_row = 3'd1; wr2_data = 5'h15; tick();
    wr2_row = 3'd6; wr2_data = 5'h1F; tick();
    wr2_row = 3'd7; tick();
    wr2_row = 3'd5; tick();
    wr2_en = 1'b0; commit2 = 1'b1; tick(); commit2 = 1'b0;
    n_total++; if (m2 !== 25'(5'h15) << 5) $display("FAIL invalid_row got %h want %h", m2, 25'(5'h15) << 5); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_diagonal();
    test_bypass();
    test_commit_busy();
    test_clear_write();
    test_reset_mid();
    test_wrap();
    test_invalid_row();
    n_total++; if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
